// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, bypass sources and execute-side outputs of the
// ID/EX stage. The stage is the slave; decode/hazard/bypass logic is the master.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
);
  // Decode slot
  logic                  stall;
  logic                  flush;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;
  logic [DATA_WIDTH-1:0] imm_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [REG_AW-1:0]     rs1_d;
  logic [REG_AW-1:0]     rs2_d;
  logic [REG_AW-1:0]     rd_d;
  logic [3:0]            alu_ctrl_d;
  logic                  alu_src_d;
  logic                  reg_write_d;
  logic                  mem_write_d;
  logic                  branch_d;
  logic [1:0]            result_src_d;

  // Bypass sources from later stages
  logic                  fwd_em_we;
  logic                  fwd_mw_we;
  logic [REG_AW-1:0]     fwd_em_rd;
  logic [REG_AW-1:0]     fwd_mw_rd;
  logic [DATA_WIDTH-1:0] fwd_em_data;
  logic [DATA_WIDTH-1:0] fwd_mw_data;

  // Execute slot
  logic [DATA_WIDTH-1:0] ALUop1;
  logic [DATA_WIDTH-1:0] ALUop2;
  logic [3:0]            ALUctrl;
  logic [DATA_WIDTH-1:0] write_data_e;
  logic [DATA_WIDTH-1:0] pc_e;
  logic [DATA_WIDTH-1:0] imm_e;
  logic [REG_AW-1:0]     rd_e;
  logic                  reg_write_e;
  logic                  mem_write_e;
  logic                  branch_e;
  logic                  valid_e;
  logic [1:0]            result_src_e;

  modport master (
    output stall, flush, valid_d, rd1_d, rd2_d, imm_d, pc_d, rs1_d, rs2_d, rd_d,
           alu_ctrl_d, alu_src_d, reg_write_d, mem_write_d, branch_d, result_src_d,
           fwd_em_we, fwd_mw_we, fwd_em_rd, fwd_mw_rd, fwd_em_data, fwd_mw_data,
    input  ALUop1, ALUop2, ALUctrl, write_data_e, pc_e, imm_e, rd_e,
           reg_write_e, mem_write_e, branch_e, valid_e, result_src_e
  );

  modport slave (
    input  stall, flush, valid_d, rd1_d, rd2_d, imm_d, pc_d, rs1_d, rs2_d, rd_d,
           alu_ctrl_d, alu_src_d, reg_write_d, mem_write_d, branch_d, result_src_d,
           fwd_em_we, fwd_mw_we, fwd_em_rd, fwd_mw_rd, fwd_em_data, fwd_mw_data,
    output ALUop1, ALUop2, ALUctrl, write_data_e, pc_e, imm_e, rd_e,
           reg_write_e, mem_write_e, branch_e, valid_e, result_src_e
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass feeding the ALU.
// Valid semantics: valid_d marks a real instruction in decode; it moves to valid_e on a load edge.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rd1_q;
  logic [DATA_WIDTH-1:0] rd2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [REG_AW-1:0]     rs1_q;
  logic [REG_AW-1:0]     rs2_q;
  logic [REG_AW-1:0]     rd_q;
  logic [3:0]            alu_ctrl_q;
  logic                  alu_src_q;
  logic                  reg_write_q;
  logic                  mem_write_q;
  logic                  branch_q;
  logic [1:0]            result_src_q;

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  // Flush outranks stall so a squashed slot never lingers behind a hold.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q      <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= 4'b0000;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      result_src_q <= 2'b00;
    end else if (!bus.stall) begin
      valid_q      <= bus.valid_d;
      rd1_q        <= bus.rd1_d;
      rd2_q        <= bus.rd2_d;
      imm_q        <= bus.imm_d;
      pc_q         <= bus.pc_d;
      rs1_q        <= bus.rs1_d;
      rs2_q        <= bus.rs2_d;
      rd_q         <= bus.rd_d;
      alu_ctrl_q   <= bus.alu_ctrl_d;
      alu_src_q    <= bus.alu_src_d;
      reg_write_q  <= bus.reg_write_d;
      mem_write_q  <= bus.mem_write_d;
      branch_q     <= bus.branch_d;
      result_src_q <= bus.result_src_d;
    end
  end

  // Youngest producer wins; x0 is hardwired zero so it is never bypassed.
  always_comb begin
    fwd_a = rd1_q;
    if (bus.fwd_em_we && (bus.fwd_em_rd != '0) && (bus.fwd_em_rd == rs1_q))
      fwd_a = bus.fwd_em_data;
    else if (bus.fwd_mw_we && (bus.fwd_mw_rd != '0) && (bus.fwd_mw_rd == rs1_q))
      fwd_a = bus.fwd_mw_data;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (bus.fwd_em_we && (bus.fwd_em_rd != '0) && (bus.fwd_em_rd == rs2_q))
      fwd_b = bus.fwd_em_data;
    else if (bus.fwd_mw_we && (bus.fwd_mw_rd != '0) && (bus.fwd_mw_rd == rs2_q))
      fwd_b = bus.fwd_mw_data;
  end

  assign bus.ALUop1       = fwd_a;
  assign bus.ALUop2       = alu_src_q ? imm_q : fwd_b;
  assign bus.write_data_e = fwd_b;
  assign bus.ALUctrl      = alu_ctrl_q;
  assign bus.pc_e         = pc_q;
  assign bus.imm_e        = imm_q;
  assign bus.rd_e         = rd_q;
  assign bus.reg_write_e  = reg_write_q;
  assign bus.mem_write_e  = mem_write_q;
  assign bus.branch_e     = branch_q;
  assign bus.valid_e      = valid_q;
  assign bus.result_src_e = result_src_q;

endmodule
